// File: rtl/lgbs_link_pkg.sv
// Link-level definitions shared with the main board: command bytes, echo FSM
// encoding, default timing constants and the byte classifier.
package lgbs_link_pkg;

    localparam logic [7:0] CMD_ON     = 8'hEE;
    localparam logic [7:0] CMD_OFF    = 8'h55;
    localparam logic [7:0] CMD_TOGGLE = 8'hC3;

    localparam int unsigned CLK_FREQ_HZ            = 24_000_000;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 72_000_000;
    localparam int unsigned DEFAULT_ACK_CYCLES     = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } echo_state_e;

    typedef enum logic [1:0] {
        CMD_KIND_ON,
        CMD_KIND_OFF,
        CMD_KIND_TOGGLE,
        CMD_KIND_INVALID
    } cmd_kind_e;

    // A byte with a parity error is never trusted, whatever its value.
    function automatic cmd_kind_e classify_cmd(input logic [7:0] rx_byte,
                                               input logic       parity_err);
        if (parity_err) begin
            return CMD_KIND_INVALID;
        end
        case (rx_byte)
            CMD_ON:     return CMD_KIND_ON;
            CMD_OFF:    return CMD_KIND_OFF;
            CMD_TOGGLE: return CMD_KIND_TOGGLE;
            default:    return CMD_KIND_INVALID;
        endcase
    endfunction

    // Inverting a corrupted byte guarantees the master sees a mismatch.
    function automatic logic [7:0] echo_byte(input logic [7:0] rx_byte,
                                             input logic       parity_err);
        return parity_err ? ~rx_byte : rx_byte;
    endfunction

endpackage

// File: rtl/cmd_echo_decoder_if.sv
// Link bundle between the UART rx/tx pair (master side) and the command
// decoder (slave side).
interface cmd_echo_decoder_if;

    logic [7:0] data_received;
    logic       rx_done;
    logic       parity_error;
    logic       tx_busy;
    logic [7:0] data_to_tx;
    logic       start_tx;
    logic       output_en;
    logic       cmd_error;
    logic       timeout;

    modport master (
        output data_received, rx_done, parity_error, tx_busy,
        input  data_to_tx, start_tx, output_en, cmd_error, timeout
    );

    modport slave (
        input  data_received, rx_done, parity_error, tx_busy,
        output data_to_tx, start_tx, output_en, cmd_error, timeout
    );

endinterface

// File: rtl/link_watchdog.sv
// Saturating link-silence counter; expired is high on every edge at which the
// count is (or stays) at LIMIT.
module link_watchdog #(
    parameter int unsigned LIMIT = 72_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_q != LIMIT_C) begin
            count_d = count_q + CW'(1);
        end
    end

    // Expiry is judged on the value being loaded, so it acts on the same edge.
    assign expired = (count_d == LIMIT_C);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cmd_echo_decoder.sv
// Decodes on/off/toggle command bytes into output_en and echoes every accepted
// byte back through uart_tx; a link watchdog forces the output off on silence.
module cmd_echo_decoder
    import lgbs_link_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned ACK_CYCLES     = DEFAULT_ACK_CYCLES
) (
    input  logic                clk,
    input  logic                reset_n,
    cmd_echo_decoder_if.slave   link
);

    localparam int unsigned ACK_CW = $clog2(ACK_CYCLES + 1);
    localparam logic [ACK_CW-1:0] ACK_LAST = ACK_CW'(ACK_CYCLES - 1);

    echo_state_e       state_q, state_d;
    logic [ACK_CW-1:0] ack_cnt_q, ack_cnt_d;
    logic [7:0]        data_to_tx_q, data_to_tx_d;
    logic              output_en_q, output_en_d;
    logic              cmd_error_q, cmd_error_d;
    logic              timeout_q, timeout_d;

    cmd_kind_e rx_kind;
    logic      accept;
    logic      ack_timeout;
    logic      wd_clear;
    logic      wd_expired;
    logic      start_tx;

    assign rx_kind     = classify_cmd(link.data_received, link.parity_error);
    assign accept      = (state_q == ST_IDLE) && link.rx_done;
    assign ack_timeout = (state_q == ST_REQ) && !link.tx_busy && (ack_cnt_q == ACK_LAST);
    assign wd_clear    = accept && (rx_kind != CMD_KIND_INVALID);

    link_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .expired (wd_expired)
    );

    // State register (all flops of the block).
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ack_cnt_q    <= '0;
            data_to_tx_q <= 8'h00;
            output_en_q  <= 1'b0;
            cmd_error_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_cnt_q    <= ack_cnt_d;
            data_to_tx_q <= data_to_tx_d;
            output_en_q  <= output_en_d;
            cmd_error_q  <= cmd_error_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state logic; bytes arriving outside IDLE are simply not looked at.
    always_comb begin
        state_d   = state_q;
        ack_cnt_d = ack_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (link.rx_done) begin
                    state_d   = ST_REQ;
                    ack_cnt_d = '0;
                end
            end
            ST_REQ: begin
                if (link.tx_busy) begin
                    state_d = ST_BUSY;
                end else if (ack_cnt_q == ACK_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_CW'(1);
                end
            end
            ST_BUSY: begin
                if (!link.tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and decode datapath. A valid command clears the watchdog, so
    // wd_expired is low on that edge and the command always wins.
    always_comb begin
        data_to_tx_d = data_to_tx_q;
        output_en_d  = output_en_q;
        cmd_error_d  = cmd_error_q;
        timeout_d    = timeout_q;
        start_tx     = (state_q == ST_REQ);

        if (wd_expired) begin
            output_en_d = 1'b0;
            timeout_d   = 1'b1;
        end

        if (accept) begin
            data_to_tx_d = echo_byte(link.data_received, link.parity_error);
            case (rx_kind)
                CMD_KIND_ON:     output_en_d = 1'b1;
                CMD_KIND_OFF:    output_en_d = 1'b0;
                CMD_KIND_TOGGLE: output_en_d = ~output_en_q;
                default:         output_en_d = output_en_d;
            endcase
            if (rx_kind == CMD_KIND_INVALID) begin
                cmd_error_d = 1'b1;
            end else begin
                cmd_error_d = 1'b0;
                timeout_d   = 1'b0;
            end
        end

        // uart_tx never acknowledged the request: report it as a link error.
        if (ack_timeout) begin
            cmd_error_d = 1'b1;
        end
    end

    assign link.data_to_tx = data_to_tx_q;
    assign link.start_tx   = start_tx;
    assign link.output_en  = output_en_q;
    assign link.cmd_error  = cmd_error_q;
    assign link.timeout    = timeout_q;

endmodule

// File: doc/cmd_echo_decoder.md
# cmd_echo_decoder

Command-side stage on each FPGA_modulo board, directly downstream of the UART receiver carrying the main board's link traffic. Decodes received command bytes (turn-on / turn-off / toggle) into a registered output-enable and echoes every byte back through the UART transmitter, so the main board can check link integrity by comparing the echo against what it sent. A link watchdog forces the output off when no valid command arrives in time.

## Interface
- `CMD_ON`, 8'hEE, turn-on command byte
- `CMD_OFF`, 8'h55, turn-off command byte
- `CMD_TOGGLE`, 8'hC3, toggle command byte
- `TIMEOUT_CYCLES`, 72_000_000, watchdog limit (3 s at 24 MHz)
- `ACK_CYCLES`, 64, max wait for `tx_busy` to rise after `start_tx`
- `clk`  in  1  system clock, 24 MHz (HFOSC/2)
- `reset_n`  in  1  synchronous, active-low reset
- `data_received`  in  8  byte from uart_rx, valid when `rx_done`=1
- `rx_done`  in  1  one-cycle strobe, byte available
- `parity_error`  in  1  qualifies the current `rx_done` byte
- `tx_busy`  in  1  uart_tx busy flag
- `data_to_tx`  out  8  echo byte to uart_tx
- `start_tx`  out  1  transmit request, level, held until `tx_busy` seen
- `output_en`  out  1  decoded enable to the SPWM/gate stage
- `cmd_error`  out  1  last received byte was invalid (parity or unknown)
- `timeout`  out  1  watchdog expired, sticky until next valid command

## Operation
- Reset (`reset_n`=0 at an edge): state IDLE, `output_en`=0, `start_tx`=0, `data_to_tx`=8'h00, `cmd_error`=0, `timeout`=0, watchdog=0. Reset mid-echo drops `start_tx` at that edge; no echo completed.
- States: IDLE, REQ, BUSY.
- IDLE + `rx_done`: classify byte, register `data_to_tx`, go REQ.
  - Valid (`CMD_ON`/`CMD_OFF`/`CMD_TOGGLE`, no parity error): apply to `output_en` (1/0/invert), `cmd_error`=0, `timeout`=0, watchdog cleared; echo = byte verbatim.
  - Unknown byte, no parity error: `output_en` unchanged, `cmd_error`=1; echo = byte verbatim.
  - Parity error (any value): `output_en` unchanged, `cmd_error`=1; echo = ~`data_received`, guaranteeing mismatch at the master.
- REQ: `start_tx`=1. `tx_busy`=1 → BUSY, `start_tx`=0. After `ACK_CYCLES` without `tx_busy` → IDLE, `start_tx`=0, `cmd_error`=1.
- BUSY: wait `tx_busy`=0 → IDLE.
- `rx_done` in REQ or BUSY: byte dropped, not decoded, not echoed, no flag change.
- Watchdog: counts every cycle, saturating at `TIMEOUT_CYCLES`; on reaching it `output_en`=0, `timeout`=1. Width $clog2(TIMEOUT_CYCLES+1).
- Simultaneous valid command and terminal count: command wins; counter clears, `timeout` stays 0, `output_en` per command.
- Toggle while timed out: applies to `output_en`=0 → 1, clears `timeout`.

## Timing
- `rx_done` at edge N → `output_en`, `cmd_error`, `data_to_tx` updated at N+1; `start_tx`=1 from N+1.
- `start_tx` falls the edge after `tx_busy` is sampled high.
- `data_to_tx` stable from REQ entry until next IDLE decode.
- Watchdog expiry: `output_en`/`timeout` change the edge the count reaches `TIMEOUT_CYCLES`.
- Back-to-back throughput: one byte per completed echo; one idle cycle min between echoes.

## Structure
- Shared package `lgbs_link_pkg`: command byte constants (shared with the main board), state encoding, default clock frequency.
- Sub-module `link_watchdog`: saturating counter with clear input and expired output.

## Test plan
- Reset, then `rx_done` with 8'hEE → `output_en`=1 at N+1, `start_tx`=1, `data_to_tx`=8'hEE; model `tx_busy` high 3 cycles later → `start_tx`=0 next edge.
- 8'hC3 twice with `output_en`=1 → 0 then 1; both echoed as 8'hC3.
- 8'h55 with `parity_error`=1 → `output_en` unchanged, `cmd_error`=1, `data_to_tx`=8'hAA.
- 8'h12 → `cmd_error`=1, echo 8'h12; second byte during BUSY → ignored, no second `start_tx`.
- `TIMEOUT_CYCLES`=100, 8'hEE then silence → `output_en`=0, `timeout`=1 exactly 100 cycles later; 8'hEE → both recover.
- `tx_busy` held 0 → `start_tx` drops after 64 cycles, `cmd_error`=1; `reset_n`=0 mid-REQ → all outputs to reset values next edge.
